// File: rtl/lenet_pkg.sv
// Shared LeNet constants and types.
// Used by the conv-2 layer and the ReLU/max-pool stage.
package lenet_pkg;
   localparam int LN_BITWIDTH = 32;
   localparam int POOL        = 2;
   localparam int C2_CHANNELS = 2;
   localparam int C2_DIM      = 10;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } pool_state_t;
endpackage

// File: rtl/max4_relu.sv
// Rectified maximum of four signed values.
// Purely combinational; one 2x2 pooling window.
module max4_relu #(
   parameter int W = 32
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] c,
   input  logic signed [W-1:0] d,
   output logic signed [W-1:0] y
);
   logic signed [W-1:0] m_ab;
   logic signed [W-1:0] m_cd;
   logic signed [W-1:0] m;

   // Two-level signed max tree, then clamp negatives to zero.
   always_comb begin
      m_ab = (a > b) ? a : b;
      m_cd = (c > d) ? c : d;
      m    = (m_ab > m_cd) ? m_ab : m_cd;
      y    = m[W-1] ? '0 : m;
   end
endmodule

// File: rtl/relu_maxpool_2.sv
// ReLU + 2x2 max-pool after conv layer 2.
// Snapshots the map on start, emits one element per cycle.
module relu_maxpool_2
   import lenet_pkg::*;
#(
   parameter int BITWIDTH = LN_BITWIDTH,
   parameter int CHANNELS = C2_CHANNELS,
   parameter int IN_DIM   = C2_DIM
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic signed [CHANNELS-1:0][IN_DIM-1:0][IN_DIM-1:0][BITWIDTH-1:0] featuremap2,
   output logic busy,
   output logic done,
   output logic signed [CHANNELS-1:0][IN_DIM/2-1:0][IN_DIM/2-1:0][BITWIDTH-1:0] featuremap3
);
   localparam int OUT = IN_DIM / POOL;
   localparam int IW  = $clog2(IN_DIM);
   localparam int RW  = $clog2(OUT);
   localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef logic [CHANNELS-1:0][IN_DIM-1:0][IN_DIM-1:0][BITWIDTH-1:0] snap_t;
   typedef logic [CHANNELS-1:0][OUT-1:0][OUT-1:0][BITWIDTH-1:0] omap_t;

   pool_state_t state_q, state_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [RW-1:0] r_q, r_d;
   logic [RW-1:0] c_q, c_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   snap_t snap_q, snap_d;
   omap_t fm3_q, fm3_d;

   logic [IW-1:0] row0, row1, col0, col1;
   logic [BITWIDTH-1:0] pool_y;
   logic last;

   // Window coordinates for the current output element.
   always_comb begin
      row0 = IW'(r_q) << 1;
      row1 = row0 + IW'(1);
      col0 = IW'(c_q) << 1;
      col1 = col0 + IW'(1);
      last = (ch_q == CW'(CHANNELS - 1))
          && (r_q == RW'(OUT - 1))
          && (c_q == RW'(OUT - 1));
   end

   max4_relu #(.W(BITWIDTH)) u_max4 (
      .a (snap_q[ch_q][row0][col0]),
      .b (snap_q[ch_q][row0][col1]),
      .c (snap_q[ch_q][row1][col0]),
      .d (snap_q[ch_q][row1][col1]),
      .y (pool_y)
   );

   // Next-state: FSM, raster counters, snapshot and output writes.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      r_d     = r_q;
      c_d     = c_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      snap_d  = snap_q;
      fm3_d   = fm3_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               snap_d  = featuremap2;
               ch_d    = '0;
               r_d     = '0;
               c_d     = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            fm3_d[ch_q][r_q][c_q] = pool_y;
            if (last) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               busy_d = 1'b1;
               if (c_q == RW'(OUT - 1)) begin
                  c_d = '0;
                  if (r_q == RW'(OUT - 1)) begin
                     r_d  = '0;
                     ch_d = ch_q + CW'(1);
                  end else begin
                     r_d = r_q + RW'(1);
                  end
               end else begin
                  c_d = c_q + RW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; synchronous reset aborts any pass.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
         r_q     <= '0;
         c_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         snap_q  <= '0;
         fm3_q   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         r_q     <= r_d;
         c_q     <= c_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         snap_q  <= snap_d;
         fm3_q   <= fm3_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign featuremap3 = fm3_q;
endmodule
